// File: rtl/data_store_buffer.sv
// Posted-write buffer between MEM and the data RAM: stores queue in a FIFO and
// retire in cycles the RAM port is not claimed by a non-aliasing load.
module data_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_ce_i,
  input  logic             mem_we_i,
  input  logic [31:0]      mem_addr_i,
  input  logic [3:0]       mem_sel_i,
  input  logic [31:0]      mem_data_i,
  output logic [31:0]      mem_data_o,
  output logic             stall_req_o,
  output logic             ram_ce_o,
  output logic             ram_we_o,
  output logic [31:0]      ram_addr_o,
  output logic [3:0]       ram_sel_o,
  output logic [31:0]      ram_data_o,
  input  logic [31:0]      ram_data_i,
  output logic [PTR_W:0]   count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [31:0]    addr_q [DEPTH];
  logic [31:0]    addr_d [DEPTH];
  logic [3:0]     sel_q  [DEPTH];
  logic [3:0]     sel_d  [DEPTH];
  logic [31:0]    data_q [DEPTH];
  logic [31:0]    data_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic load_req;
  logic store_req;
  logic conflict;
  logic grant_load;
  logic push;
  logic pop;
  logic [PTR_W-1:0] idx;

  assign load_req  = mem_ce_i & ~mem_we_i;
  assign store_req = mem_ce_i & mem_we_i;

  // Only entries between head and head+count are live; stale slots never alias.
  always_comb begin
    conflict = 1'b0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (((PTR_W+1)'(i) < count_q) && (addr_q[idx][31:2] == mem_addr_i[31:2]))
        conflict = 1'b1;
    end
  end

  assign grant_load = load_req & ~conflict;
  assign pop        = ~rst & ~grant_load & (count_q != '0);
  assign push       = ~rst & store_req;

  always_comb begin
    ram_ce_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_sel_o   = '0;
    ram_data_o  = '0;
    mem_data_o  = '0;
    stall_req_o = 1'b0;
    if (!rst) begin
      if (grant_load) begin
        ram_ce_o   = 1'b1;
        ram_addr_o = mem_addr_i;
        ram_sel_o  = 4'b1111;
        mem_data_o = ram_data_i;
      end else if (count_q != '0) begin
        ram_ce_o    = 1'b1;
        ram_we_o    = 1'b1;
        ram_addr_o  = addr_q[head_q];
        ram_sel_o   = sel_q[head_q];
        ram_data_o  = data_q[head_q];
        stall_req_o = load_req;
      end
    end
  end

  // A full FIFO always drains on a store cycle, so the tail slot is already free.
  always_comb begin
    addr_d  = addr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      addr_d[tail_q] = mem_addr_i;
      sel_d[tail_q]  = mem_sel_i;
      data_d[tail_q] = mem_data_i;
      tail_d         = tail_q + 1'b1;
    end
    if (pop)
      head_d = head_q + 1'b1;
    if (push && !pop)
      count_d = count_q + 1'b1;
    else if (pop && !push)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    sel_q  <= sel_d;
    data_q <= data_d;
  end

  assign count_o = count_q;
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: tb/tb_data_store_buffer.sv
// Randomized plus directed bench for data_store_buffer, checked against a
// queue-and-array model of the buffer and the RAM contents it should produce.
module tb_data_store_buffer;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic        clk;
  logic        rst;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        stall_req_o;
  logic        ram_ce_o;
  logic        ram_we_o;
  logic [31:0] ram_addr_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_data_o;
  logic [31:0] ram_data_i;
  logic [PTR_W:0] count_o;
  logic        full_o;
  logic        empty_o;

  data_store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_sel_i(mem_sel_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
    .stall_req_o(stall_req_o), .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o),
    .ram_addr_o(ram_addr_o), .ram_sel_o(ram_sel_o), .ram_data_o(ram_data_o),
    .ram_data_i(ram_data_i), .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
  } entry_t;

  entry_t      model_q[$];
  logic [31:0] model_mem [128];
  logic [31:0] ram_mem   [128];
  int          checks;
  int          errors;
  logic        model_pop;
  logic        model_stall;

  // Environment RAM: combinational read, byte-lane write at the edge.
  assign ram_data_i = ram_mem[ram_addr_o[8:2]];

  always @(posedge clk) begin
    if (ram_ce_o && ram_we_o) begin
      for (int b = 0; b < 4; b++)
        if (ram_sel_o[b])
          ram_mem[ram_addr_o[8:2]][b*8 +: 8] <= ram_data_o[b*8 +: 8];
    end
  end

  function automatic logic [31:0] merge_lanes(logic [31:0] old_w, logic [3:0] sel,
                                              logic [31:0] data);
    logic [31:0] w;
    w = old_w;
    for (int b = 0; b < 4; b++)
      if (sel[b]) w[b*8 +: 8] = data[b*8 +: 8];
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic ce, input logic we,
                               input logic [31:0] addr, input logic [3:0] sel,
                               input logic [31:0] data);
    rst        = r;
    mem_ce_i   = ce;
    mem_we_i   = we;
    mem_addr_i = addr;
    mem_sel_i  = sel;
    mem_data_i = data;
  endtask

  // Predict this cycle's outputs from the model and compare.
  task automatic checkOutput();
    logic        is_load;
    logic        alias_hit;
    logic [31:0] e_addr, e_data, e_mdata;
    logic [3:0]  e_sel;
    logic        e_ce, e_we, e_stall;
    is_load   = mem_ce_i && !mem_we_i;
    alias_hit = 1'b0;
    foreach (model_q[i])
      if (model_q[i].addr[31:2] == mem_addr_i[31:2]) alias_hit = 1'b1;
    e_ce = 0; e_we = 0; e_addr = 0; e_sel = 0; e_data = 0; e_mdata = 0; e_stall = 0;
    model_pop = 1'b0;
    if (rst) begin
      model_pop = 1'b0;
    end else if (is_load && !alias_hit) begin
      e_ce = 1; e_addr = mem_addr_i; e_sel = 4'hF;
      e_mdata = model_mem[mem_addr_i[8:2]];
    end else if (model_q.size() > 0) begin
      e_ce = 1; e_we = 1;
      e_addr = model_q[0].addr; e_sel = model_q[0].sel; e_data = model_q[0].data;
      e_stall = is_load;
      model_pop = 1'b1;
    end
    model_stall = e_stall;
    chk("ram_ce", 32'(ram_ce_o), 32'(e_ce));
    chk("ram_we", 32'(ram_we_o), 32'(e_we));
    chk("ram_addr", ram_addr_o, e_addr);
    chk("ram_sel", 32'(ram_sel_o), 32'(e_sel));
    chk("ram_data", ram_data_o, e_data);
    chk("mem_data", mem_data_o, e_mdata);
    chk("stall", 32'(stall_req_o), 32'(e_stall));
    if (!rst) begin
      chk("count", 32'(count_o), 32'(model_q.size()));
      chk("empty", 32'(empty_o), 32'(model_q.size() == 0));
      chk("full", 32'(full_o), 32'(model_q.size() == DEPTH));
    end
  endtask

  task automatic step(input logic r, input logic ce, input logic we,
                      input logic [31:0] addr, input logic [3:0] sel,
                      input logic [31:0] data);
    applyStimulus(r, ce, we, addr, sel, data);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    if (r) begin
      model_q.delete();
    end else begin
      if (model_pop) begin
        model_mem[model_q[0].addr[8:2]] =
          merge_lanes(model_mem[model_q[0].addr[8:2]], model_q[0].sel, model_q[0].data);
        void'(model_q.pop_front());
      end
      if (ce && we) model_q.push_back('{addr: addr, sel: sel, data: data});
    end
    #1;
  endtask

  initial begin
    logic        ce, we;
    logic [31:0] addr, data;
    logic [3:0]  sel;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 128; i++) begin
      model_mem[i] = '0;
      ram_mem[i]   = '0;
    end
    applyStimulus(1, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    $display("[TB] reset");
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    $display("[TB] single store then idle");
    step(0, 1, 1, 32'h10, 4'hF, 32'hDEADBEEF);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 32'h10, 0, 0);
    chk("load_0x10", mem_data_o, 32'hDEADBEEF);

    $display("[TB] load after store conflict");
    step(0, 1, 1, 32'h20, 4'b0001, 32'h000000AA);
    step(0, 1, 0, 32'h22, 0, 0);
    step(0, 1, 0, 32'h22, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    $display("[TB] non-conflicting load priority");
    step(0, 1, 1, 32'h40, 4'hF, 32'h11112222);
    step(0, 1, 0, 32'h80, 0, 0);
    step(0, 1, 1, 32'h44, 4'b1100, 32'h33334444);
    step(0, 1, 0, 32'h44, 0, 0);
    step(0, 1, 0, 32'h44, 0, 0);

    $display("[TB] back-to-back stores");
    for (int k = 0; k < 6; k++)
      step(0, 1, 1, 32'h100 + 32'(k * 4), 4'hF, 32'hA000_0000 + 32'(k));
    step(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++)
      step(0, 1, 0, 32'h100 + 32'(k * 4), 0, 0);

    $display("[TB] reset discards pending store");
    step(0, 1, 1, 32'h30, 4'hF, 32'hBADBAD00);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 32'h30, 0, 0);
    chk("discarded_0x30", mem_data_o, 32'h0);

    $display("[TB] random traffic");
    ce = 0; we = 0; addr = 0; sel = 0; data = 0;
    for (int n = 0; n < 400; n++) begin
      if (!model_stall) begin
        ce   = ($urandom % 4) != 0;
        we   = $urandom % 2;
        addr = {23'b0, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 2'($urandom % 4)};
        sel  = 4'($urandom);
        data = $urandom;
      end
      if (n == 200) step(1, ce, we, addr, sel, data);
      else          step(0, ce, we, addr, sel, data);
    end
    for (int n = 0; n < 4; n++) step(0, 0, 0, 0, 0, 0);
    chk("final_empty", 32'(empty_o), 32'h1);
    for (int i = 0; i < 128; i++)
      chk("ram_contents", ram_mem[i], model_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
